rename_register_file: RTL and testbench

RENAME_REGISTER_FILE -- requirements
Module: rename_register_file

---
 rtl/rename_register_file.sv | 125 ++++++++++++
 tb/tb_rename_register_file.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rename_register_file.sv
`default_nettype none
// ============================================================================
// Module      : rename_register_file
// Description : Register-rename status table. Each architectural register
//               holds a valid bit, the ROB tag of its pending producer and
//               its committed data. Supports multi-port combinational reads
//               with optional same-cycle commit forwarding, destination
//               renaming, multi-port tag-matched writeback and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_register_file #(
    parameter int REG_WIDTH  = 5,
    parameter int ROB_WIDTH  = 3,
    parameter int DATA_WIDTH = 32,
    parameter int N_READ     = 2,
    parameter int N_COMMIT   = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_WIDTH-1:0]  read_reg     [N_READ],
    output logic                  read_valid   [N_READ],
    output logic [ROB_WIDTH-1:0]  read_tag     [N_READ],
    output logic [DATA_WIDTH-1:0] read_data    [N_READ],
    input  logic                  issue,
    input  logic [REG_WIDTH-1:0]  issue_reg,
    input  logic [ROB_WIDTH-1:0]  issue_tag,
    input  logic                  commit       [N_COMMIT],
    input  logic [ROB_WIDTH-1:0]  commit_tag   [N_COMMIT],
    input  logic [DATA_WIDTH-1:0] commit_data  [N_COMMIT],
    input  logic                  flush,
    output logic [REG_WIDTH:0]    pending_count
);

    localparam int c_DEPTH = 2 ** REG_WIDTH;
    localparam int c_CNT_W = REG_WIDTH + 1;

    logic                  r_valid [c_DEPTH];
    logic [ROB_WIDTH-1:0]  r_tag   [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_data  [c_DEPTH];
    logic [c_CNT_W-1:0]    r_pending;

    logic                  w_valid_nxt [c_DEPTH];
    logic [ROB_WIDTH-1:0]  w_tag_nxt   [c_DEPTH];
    logic [DATA_WIDTH-1:0] w_data_nxt  [c_DEPTH];
    logic [c_CNT_W-1:0]    w_pending_nxt;

    // Next state of every entry: commit writeback first (later ports override
    // earlier ones), then flush revalidates or issue re-renames the entry.
    always_comb begin
        for (int i = 0; i < c_DEPTH; i++) begin
            w_valid_nxt[i] = r_valid[i];
            w_tag_nxt[i]   = r_tag[i];
            w_data_nxt[i]  = r_data[i];
            for (int k = 0; k < N_COMMIT; k++) begin
                if (commit[k] && !r_valid[i] && (r_tag[i] == commit_tag[k])) begin
                    w_data_nxt[i]  = commit_data[k];
                    w_valid_nxt[i] = 1'b1;
                end
            end
            if (flush) begin
                w_valid_nxt[i] = 1'b1;
            end else if (issue && (issue_reg == REG_WIDTH'(i))) begin
                w_valid_nxt[i] = 1'b0;
                w_tag_nxt[i]   = issue_tag;
            end
            // Entry 0 is a constant zero register when enabled
            if ((ZERO_REG != 0) && (i == 0)) begin
                w_valid_nxt[i] = 1'b1;
                w_tag_nxt[i]   = '0;
                w_data_nxt[i]  = '0;
            end
        end
    end

    // Count of entries that will be pending after the coming edge
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_pending_nxt = w_pending_nxt + {{REG_WIDTH{1'b0}}, ~w_valid_nxt[i]};
        end
    end

    // Entry storage and pending counter; reset makes every entry valid
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_valid[i] <= 1'b1;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_valid[i] <= w_valid_nxt[i];
                r_tag[i]   <= w_tag_nxt[i];
                r_data[i]  <= w_data_nxt[i];
            end
            r_pending <= w_pending_nxt;
        end
    end

    // Combinational read ports with optional forwarding of same-cycle commits
    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            read_valid[p] = r_valid[read_reg[p]];
            read_tag[p]   = r_tag[read_reg[p]];
            read_data[p]  = r_data[read_reg[p]];
            if (BYPASS != 0) begin
                for (int k = 0; k < N_COMMIT; k++) begin
                    if (commit[k] && !r_valid[read_reg[p]] &&
                        (r_tag[read_reg[p]] == commit_tag[k])) begin
                        read_valid[p] = 1'b1;
                        read_data[p]  = commit_data[k];
                    end
                end
            end
        end
    end

    assign pending_count = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rename_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_register_file
// Description : Directed, table-driven bench for rename_register_file with
//               default parameters, plus hand-written fill/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  read_reg    [2];
    logic        read_valid  [2];
    logic [2:0]  read_tag    [2];
    logic [31:0] read_data   [2];
    logic        issue;
    logic [4:0]  issue_reg;
    logic [2:0]  issue_tag;
    logic        commit      [2];
    logic [2:0]  commit_tag  [2];
    logic [31:0] commit_data [2];
    logic        flush;
    logic [5:0]  pending_count;

    int errors = 0;
    int checks = 0;

    rename_register_file dut (
        .clk          (clk),
        .reset        (reset),
        .read_reg     (read_reg),
        .read_valid   (read_valid),
        .read_tag     (read_tag),
        .read_data    (read_data),
        .issue        (issue),
        .issue_reg    (issue_reg),
        .issue_tag    (issue_tag),
        .commit       (commit),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .flush        (flush),
        .pending_count(pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic [4:0]  ireg;
        logic [2:0]  itag;
        logic        c0;
        logic [2:0]  ct0;
        logic [31:0] cd0;
        logic        c1;
        logic [2:0]  ct1;
        logic [31:0] cd1;
        logic        fl;
        logic [4:0]  rr0;
        logic [4:0]  rr1;
        logic        ev0;
        logic [2:0]  et0;
        logic [31:0] ed0;
        logic        ev1;
        logic [2:0]  et1;
        logic [31:0] ed1;
        logic [5:0]  epend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic iss, input logic [4:0] ireg, input logic [2:0] itag,
        input logic c0, input logic [2:0] ct0, input logic [31:0] cd0,
        input logic c1, input logic [2:0] ct1, input logic [31:0] cd1,
        input logic fl, input logic [4:0] rr0, input logic [4:0] rr1,
        input logic ev0, input logic [2:0] et0, input logic [31:0] ed0,
        input logic ev1, input logic [2:0] et1, input logic [31:0] ed1,
        input logic [5:0] epend);
        vec_t v;
        v.iss = iss; v.ireg = ireg; v.itag = itag;
        v.c0 = c0; v.ct0 = ct0; v.cd0 = cd0;
        v.c1 = c1; v.ct1 = ct1; v.cd1 = cd1;
        v.fl = fl; v.rr0 = rr0; v.rr1 = rr1;
        v.ev0 = ev0; v.et0 = et0; v.ed0 = ed0;
        v.ev1 = ev1; v.et1 = et1; v.ed1 = ed1;
        v.epend = epend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        issue = 1'b0; issue_reg = '0; issue_tag = '0;
        commit[0] = 1'b0; commit_tag[0] = '0; commit_data[0] = '0;
        commit[1] = 1'b0; commit_tag[1] = '0; commit_data[1] = '0;
        flush = 1'b0;
        read_reg[0] = '0; read_reg[1] = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset held with activity on the inputs, which must be ignored
        @(negedge clk);
        issue = 1'b1; issue_reg = 5'd5; issue_tag = 3'd3; flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        chk("reset_pending", 32'(pending_count), 32'd0);

        // iss ireg itag | c0 ct0 cd0 | c1 ct1 cd1 | fl rr0 rr1 | ev0 et0 ed0 | ev1 et1 ed1 | pend
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd5,5'd0, 1,3'd0,32'h0, 1,3'd0,32'h0, 6'd0));
        vecs.push_back(mk(1,5'd3,3'd2, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd3,5'd5, 1,3'd0,32'h0, 1,3'd0,32'h0, 6'd1));
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd3,5'd4, 0,3'd2,32'h0, 1,3'd0,32'h0, 6'd1));
        vecs.push_back(mk(0,5'd0,3'd0, 1,3'd2,32'hDEADBEEF, 0,3'd0,32'h0, 0,5'd3,5'd2, 1,3'd2,32'hDEADBEEF, 1,3'd0,32'h0, 6'd0));
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd3,5'd3, 1,3'd2,32'hDEADBEEF, 1,3'd2,32'hDEADBEEF, 6'd0));
        vecs.push_back(mk(1,5'd3,3'd2, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd3,5'd0, 1,3'd2,32'hDEADBEEF, 1,3'd0,32'h0, 6'd1));
        vecs.push_back(mk(1,5'd3,3'd5, 1,3'd2,32'h11, 0,3'd0,32'h0, 0,5'd3,5'd0, 1,3'd2,32'h11, 1,3'd0,32'h0, 6'd1));
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd3,5'd0, 0,3'd5,32'h11, 1,3'd0,32'h0, 6'd1));
        vecs.push_back(mk(1,5'd4,3'd1, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd4,5'd3, 1,3'd0,32'h0, 0,3'd5,32'h11, 6'd2));
        vecs.push_back(mk(0,5'd0,3'd0, 1,3'd6,32'h99, 1,3'd1,32'h77, 0,5'd4,5'd3, 1,3'd1,32'h77, 0,3'd5,32'h11, 6'd1));
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd4,5'd3, 1,3'd1,32'h77, 0,3'd5,32'h11, 6'd1));
        vecs.push_back(mk(0,5'd0,3'd0, 1,3'd5,32'hAAAA, 1,3'd5,32'hBBBB, 0,5'd3,5'd4, 1,3'd5,32'hBBBB, 1,3'd1,32'h77, 6'd0));
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd3,5'd4, 1,3'd5,32'hBBBB, 1,3'd1,32'h77, 6'd0));
        vecs.push_back(mk(1,5'd1,3'd1, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd1,5'd9, 1,3'd0,32'h0, 1,3'd0,32'h0, 6'd1));
        vecs.push_back(mk(1,5'd2,3'd2, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd1,5'd2, 0,3'd1,32'h0, 1,3'd0,32'h0, 6'd2));
        vecs.push_back(mk(1,5'd7,3'd3, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd7,5'd2, 1,3'd0,32'h0, 0,3'd2,32'h0, 6'd3));
        vecs.push_back(mk(1,5'd9,3'd4, 1,3'd3,32'h33, 0,3'd0,32'h0, 1,5'd7,5'd9, 1,3'd3,32'h33, 1,3'd0,32'h0, 6'd0));
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd1,5'd7, 1,3'd1,32'h0, 1,3'd3,32'h33, 6'd0));
        vecs.push_back(mk(0,5'd0,3'd0, 0,3'd0,32'h0, 0,3'd0,32'h0, 0,5'd2,5'd9, 1,3'd2,32'h0, 1,3'd0,32'h0, 6'd0));
        vecs.push_back(mk(0,5'd0,3'd0, 1,3'd1,32'h55, 0,3'd0,32'h0, 0,5'd1,5'd1, 1,3'd1,32'h0, 1,3'd1,32'h0, 6'd0));

        // Apply one vector per cycle: reads checked before the edge, count after
        foreach (vecs[n]) begin
            issue = vecs[n].iss; issue_reg = vecs[n].ireg; issue_tag = vecs[n].itag;
            commit[0] = vecs[n].c0; commit_tag[0] = vecs[n].ct0; commit_data[0] = vecs[n].cd0;
            commit[1] = vecs[n].c1; commit_tag[1] = vecs[n].ct1; commit_data[1] = vecs[n].cd1;
            flush = vecs[n].fl;
            read_reg[0] = vecs[n].rr0; read_reg[1] = vecs[n].rr1;
            #1;
            chk($sformatf("v%0d_valid0", n), 32'(read_valid[0]), 32'(vecs[n].ev0));
            chk($sformatf("v%0d_tag0",   n), 32'(read_tag[0]),   32'(vecs[n].et0));
            chk($sformatf("v%0d_data0",  n), read_data[0],       vecs[n].ed0);
            chk($sformatf("v%0d_valid1", n), 32'(read_valid[1]), 32'(vecs[n].ev1));
            chk($sformatf("v%0d_tag1",   n), 32'(read_tag[1]),   32'(vecs[n].et1));
            chk($sformatf("v%0d_data1",  n), read_data[1],       vecs[n].ed1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pending", n), 32'(pending_count), 32'(vecs[n].epend));
            @(negedge clk);
        end
        idle_inputs();

        // Fill every entry on consecutive cycles; the count climbs to 32
        for (int i = 0; i < 32; i++) begin
            issue = 1'b1; issue_reg = 5'(i); issue_tag = 3'(i);
            @(posedge clk);
            #1;
            chk($sformatf("fill_pending_%0d", i), 32'(pending_count), 32'(i + 1));
            @(negedge clk);
        end
        // Re-issuing an already pending entry keeps the count saturated at 32
        issue = 1'b1; issue_reg = 5'd0; issue_tag = 3'd7;
        @(posedge clk);
        #1;
        chk("fill_pending_hold", 32'(pending_count), 32'd32);
        @(negedge clk);
        idle_inputs();
        read_reg[0] = 5'd31; read_reg[1] = 5'd0;
        #1;
        chk("fill_r31_valid", 32'(read_valid[0]), 32'd0);
        chk("fill_r31_tag",   32'(read_tag[0]),   32'd7);
        chk("fill_r0_tag",    32'(read_tag[1]),   32'd7);

        // Reset with issue/commit/flush all asserted: everything must be ignored
        @(negedge clk);
        reset = 1'b1;
        issue = 1'b1; issue_reg = 5'd6; issue_tag = 3'd2;
        commit[0] = 1'b1; commit_tag[0] = 3'd7; commit_data[0] = 32'h1234;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pending", 32'(pending_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 32; i += 2) begin
            read_reg[0] = 5'(i); read_reg[1] = 5'(i + 1);
            #1;
            chk($sformatf("rst_valid_%0d", i),     32'(read_valid[0]), 32'd1);
            chk($sformatf("rst_valid_%0d", i + 1), 32'(read_valid[1]), 32'd1);
            chk($sformatf("rst_data_%0d", i),      read_data[0],       32'h0);
            chk($sformatf("rst_tag_%0d", i + 1),   32'(read_tag[1]),   32'd0);
        end

        // First edge after reset release behaves normally
        @(negedge clk);
        issue = 1'b1; issue_reg = 5'd6; issue_tag = 3'd3;
        @(posedge clk);
        #1;
        chk("post_rst_pending", 32'(pending_count), 32'd1);
        @(negedge clk);
        idle_inputs();
        read_reg[0] = 5'd6;
        #1;
        chk("post_rst_r6_valid", 32'(read_valid[0]), 32'd0);
        chk("post_rst_r6_tag",   32'(read_tag[0]),   32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
